// File: rtl/life_gen_if.sv
// life_gen_if: start/load/read handshake bundle for the life generation controller
interface life_gen_if #(parameter int W = 8, H = 8, GEN_W = 16);
  localparam int AW = $clog2(W * H);
  logic start;
  logic load_we;
  logic [AW-1:0] load_addr;
  logic load_data;
  logic [AW-1:0] rd_addr;
  logic rd_data;
  logic busy;
  logic done;
  logic [GEN_W-1:0] gen_count;
  modport master (output start, load_we, load_addr, load_data, rd_addr,
                  input rd_data, busy, done, gen_count);
  modport slave (input start, load_we, load_addr, load_data, rd_addr,
                 output rd_data, busy, done, gen_count);
endinterface

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: B3/S23 Game of Life stepper, one cell per cycle; define LIFE_WRAP_EN for toroidal edges
module life_gen_ctrl #(
  parameter int W = 8,
  parameter int H = 8,
  parameter int GEN_W = 16
) (
  input logic clk,
  input logic rst,
  life_gen_if.slave bus
);
  localparam int N = W * H;
  localparam int AW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state;
  logic [N-1:0] cur, nxt;
  logic [AW-1:0] idx;
  logic busy, done, alive;
  logic [GEN_W-1:0] gen;
  logic [3:0] cnt;
  int xi, yi, nx, ny;
  always_comb begin
    xi = int'(idx) % W;
    yi = int'(idx) / W;
    nx = 0;
    ny = 0;
    cnt = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
`ifdef LIFE_WRAP_EN
        nx = (xi + dx + W) % W;
        ny = (yi + dy + H) % H;
        if (dx != 0 || dy != 0) cnt = cnt + 4'(cur[AW'(ny * W + nx)]);
`else
        nx = xi + dx;
        ny = yi + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H)
          cnt = cnt + 4'(cur[AW'(ny * W + nx)]);
`endif
      end
    alive = cur[idx] ? (cnt == 4'd2 || cnt == 4'd3) : cnt == 4'd3;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      nxt <= '0;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      gen <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_we && int'(bus.load_addr) < N) cur[bus.load_addr] <= bus.load_data;
          if (bus.start) begin
            state <= SCAN;
            idx <= '0;
            busy <= 1'b1;
          end
        end
        SCAN: begin
          nxt[idx] <= alive;
          idx <= idx + 1'b1;
          if (int'(idx) == N - 1) state <= COMMIT;
        end
        COMMIT: begin
          cur <= nxt;
          gen <= gen + 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          idx <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.rd_data = int'(bus.rd_addr) < N ? cur[bus.rd_addr] : 1'b0;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.gen_count = gen;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: directed vector bench for life_gen_ctrl (8x8 main instance, 3x3 GEN_W=2 instance)
module tb_life_gen_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  life_gen_if #(.W(8), .H(8), .GEN_W(16)) bus ();
  life_gen_if #(.W(3), .H(3), .GEN_W(2)) sb ();
  life_gen_ctrl #(.W(8), .H(8), .GEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  life_gen_ctrl #(.W(3), .H(3), .GEN_W(2)) dut_s (.clk(clk), .rst(rst), .bus(sb));
  typedef struct {
    string name;
    logic [63:0] seed;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[5];
  int n_chk = 0;
  int n_fail = 0;
  int exp_gen = 0;
  localparam logic [63:0] ONE = 64'd1;
  localparam logic [63:0] BLINK_V = (ONE << 19) | (ONE << 27) | (ONE << 35);
  localparam logic [63:0] BLINK_H = (ONE << 26) | (ONE << 27) | (ONE << 28);
  localparam logic [63:0] BLOCK = (ONE << 9) | (ONE << 10) | (ONE << 17) | (ONE << 18);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_grid(input logic [63:0] g);
    for (int i = 0; i < 64; i++) begin
      bus.load_we = 1'b1;
      bus.load_addr = 6'(i);
      bus.load_data = g[i];
      tick();
    end
    bus.load_we = 1'b0;
  endtask
  task automatic read_grid(output logic [63:0] g);
    for (int i = 0; i < 64; i++) begin
      bus.rd_addr = 6'(i);
      #1;
      g[i] = bus.rd_data;
    end
  endtask
  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int bc, output bit got);
    bc = 0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++)
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        bc += (bus.busy === 1'b1) ? 1 : 0;
        tick();
      end
  endtask
  initial begin
    logic [63:0] g;
    int bc, dn, bz;
    bit got;
    bus.start = 1'b0; bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = 1'b0; bus.rd_addr = '0;
    sb.start = 1'b0; sb.load_we = 1'b0; sb.load_addr = '0; sb.load_data = 1'b0; sb.rd_addr = '0;
    vecs[0] = '{name: "blinker", seed: BLINK_V, exp: BLINK_H};
    vecs[1] = '{name: "block", seed: BLOCK, exp: BLOCK};
`ifdef LIFE_WRAP_EN
    vecs[2] = '{name: "corner", seed: ONE | (ONE << 7) | (ONE << 56),
                exp: ONE | (ONE << 7) | (ONE << 56) | (ONE << 63)};
`else
    vecs[2] = '{name: "corner", seed: ONE | (ONE << 7) | (ONE << 56), exp: 64'd0};
`endif
    vecs[3] = '{name: "plus", seed: (ONE << 19) | (ONE << 26) | (ONE << 27) | (ONE << 28) | (ONE << 35),
                exp: (ONE << 18) | (ONE << 19) | (ONE << 20) | (ONE << 26) | (ONE << 28) |
                     (ONE << 34) | (ONE << 35) | (ONE << 36)};
    vecs[4] = '{name: "pair", seed: ONE | (ONE << 1), exp: 64'd0};
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_done", 64'(bus.done), 0);
    chk("reset_gen", 64'(bus.gen_count), 0);
    read_grid(g);
    chk("reset_grid", g, 0);
    for (int v = 0; v < 5; v++) begin
      load_grid(vecs[v].seed);
      bus.rd_addr = 6'd27;
      launch();
      wait_done(bc, got);
      exp_gen++;
      chk($sformatf("%s_busy", vecs[v].name), 64'(bc), 65);
      chk($sformatf("%s_done", vecs[v].name), 64'(got), 1);
      chk($sformatf("%s_probe", vecs[v].name), 64'(bus.rd_data), 64'(vecs[v].exp[27]));
      chk($sformatf("%s_gen", vecs[v].name), 64'(bus.gen_count), 64'(exp_gen));
      tick();
      chk($sformatf("%s_done_len", vecs[v].name), 64'(bus.done), 0);
      read_grid(g);
      chk($sformatf("%s_grid", vecs[v].name), g, vecs[v].exp);
    end
    load_grid(BLOCK);
    for (int k = 0; k < 3; k++) begin
      launch();
      wait_done(bc, got);
      exp_gen++;
      chk($sformatf("b2b%0d_busy", k), 64'(bc), 65);
      chk($sformatf("b2b%0d_done", k), 64'(got), 1);
    end
    chk("b2b_gen", 64'(bus.gen_count), 64'(exp_gen));
    tick();
    read_grid(g);
    chk("b2b_grid", g, BLOCK);
    load_grid((ONE << 9) | (ONE << 10));
    bus.load_we = 1'b1;
    bus.load_addr = 6'd17;
    bus.load_data = 1'b1;
    launch();
    bus.load_we = 1'b0;
    wait_done(bc, got);
    exp_gen++;
    chk("ldstart_done", 64'(got), 1);
    tick();
    read_grid(g);
    chk("ldstart_grid", g, BLOCK);
    load_grid(BLINK_V);
    launch();
    bc = 0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++)
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        bc += (bus.busy === 1'b1) ? 1 : 0;
        bus.start = (c == 10);
        bus.load_we = (c == 10);
        bus.load_addr = 6'd0;
        bus.load_data = 1'b1;
        tick();
      end
    bus.start = 1'b0;
    bus.load_we = 1'b0;
    exp_gen++;
    chk("ignore_busy", 64'(bc), 65);
    chk("ignore_done", 64'(got), 1);
    chk("ignore_gen", 64'(bus.gen_count), 64'(exp_gen));
    dn = 0;
    bz = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      dn += (bus.done === 1'b1) ? 1 : 0;
      bz += (bus.busy === 1'b1) ? 1 : 0;
    end
    chk("ignore_no_requeue", 64'(dn + bz), 0);
    read_grid(g);
    chk("ignore_grid", g, BLINK_H);
    load_grid(BLINK_V);
    launch();
    for (int c = 0; c < 20; c++) tick();
    chk("abort_busy_pre", 64'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_gen = 0;
    chk("abort_busy", 64'(bus.busy), 0);
    dn = 0;
    bz = 0;
    for (int c = 0; c < 80; c++) begin
      dn += (bus.done === 1'b1) ? 1 : 0;
      bz += (bus.busy === 1'b1) ? 1 : 0;
      tick();
    end
    chk("abort_no_done", 64'(dn + bz), 0);
    chk("abort_gen", 64'(bus.gen_count), 0);
    read_grid(g);
    chk("abort_grid", g, 0);
    bus.load_we = 1'b1;
    bus.load_addr = 6'd5;
    bus.load_data = 1'b1;
    bus.start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.load_we = 1'b0;
    bus.start = 1'b0;
    chk("rstdom_busy", 64'(bus.busy), 0);
    bus.rd_addr = 6'd5;
    #1;
    chk("rstdom_cell", 64'(bus.rd_data), 0);
    sb.load_we = 1'b1;
    sb.load_addr = 4'd12;
    sb.load_data = 1'b1;
    tick();
    sb.load_addr = 4'd4;
    tick();
    sb.load_we = 1'b0;
    sb.rd_addr = 4'd12;
    #1;
    chk("oob_rd", 64'(sb.rd_data), 0);
    sb.rd_addr = 4'd4;
    #1;
    chk("inrange_rd", 64'(sb.rd_data), 1);
    sb.load_we = 1'b1;
    sb.load_data = 1'b0;
    tick();
    sb.load_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb.start = 1'b1;
      tick();
      sb.start = 1'b0;
      bc = 0;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++)
        if (sb.done === 1'b1) got = 1'b1;
        else begin
          bc += (sb.busy === 1'b1) ? 1 : 0;
          tick();
        end
      chk($sformatf("small%0d_busy", k), 64'(bc), 10);
      chk($sformatf("small%0d_gen", k), 64'(sb.gen_count), 64'((k + 1) % 4));
    end
    g = 0;
    for (int i = 0; i < 16; i++) begin
      sb.rd_addr = 4'(i);
      #1;
      g[i] = sb.rd_data;
    end
    chk("small_grid", g, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/life_gen_ctrl.md
LIFE_GEN_CTRL -- requirements
Module: life_gen_ctrl

Interface
REQ-001 Parameter W, default 8: grid width in cells (>=3).
REQ-002 Parameter H, default 8: grid height in cells (>=3).
REQ-003 Parameter GEN_W, default 16: generation counter width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  request one generation step; sampled only in IDLE.
REQ-007 Load_we  input  1  write strobe for current-grid cell.
REQ-008 Load_addr  input  AW=clog2(W*H)  row-major cell index (y*W+x).
REQ-009 Load_data  input  1  cell value to write (1 = alive).
REQ-010 Rd_addr  input  AW  row-major read index.
REQ-011 Rd_data  output  1  combinational current-grid value at Rd_addr.
REQ-012 Busy  output  1  high while a generation step is in progress.
REQ-013 Done  output  1  one-cycle pulse when a step completes.
REQ-014 Gen_count  output  GEN_W  completed generations since reset.

Function
REQ-015 Internal state SHALL be: current grid (W*H bits), next grid (W*H bits), scan index, FSM {IDLE, SCAN, COMMIT}.
REQ-016 IDLE: Start=1 -> SCAN with index 0, Busy=1 from the next cycle; Start=0 -> stay.
REQ-017 SCAN: one cell per cycle, index 0..W*H-1 row-major; next[i] = alive rule on current grid only.
REQ-018 Rule SHALL be B3/S23: live cell with 2 or 3 live neighbours survives; dead cell with exactly 3 becomes live; else dead.
REQ-019 Neighbour count SHALL be the true 0..8 sum of the 8 neighbours, held in 4 bits; no parity shortcuts.
REQ-020 SCAN at index W*H-1 -> COMMIT; COMMIT copies next grid into current grid in one cycle -> IDLE.
REQ-021 Busy SHALL be high for exactly W*H+1 cycles (SCAN + COMMIT) per accepted Start.
REQ-022 Done SHALL pulse for the single cycle after COMMIT; Rd_data reflects the new generation in that cycle.
REQ-023 Gen_count SHALL increment on the COMMIT edge and wrap from 2^GEN_W-1 to 0.
REQ-024 Start while Busy SHALL be ignored (not queued).
REQ-025 Load_we while Busy SHALL be ignored; the grid under evaluation never changes mid-step.
REQ-026 Load_we and Start in the same IDLE cycle: load SHALL be written at that edge and used by the scan.
REQ-027 Load_addr or Rd_addr >= W*H: writes dropped, Rd_data=0.
REQ-028 Start on the Done cycle SHALL be accepted (back-to-back generations).

Reset
REQ-029 Rst=1 at a rising edge SHALL force IDLE, clear both grids, scan index=0, Busy=0, Done=0, Gen_count=0.
REQ-030 Rst during SCAN/COMMIT SHALL abort the step: no Done, no Gen_count increment.
REQ-031 Rst SHALL dominate Start and Load_we in the same cycle.

Configuration
REQ-032 Macro LIFE_WRAP_EN defined: edges are toroidal; x-1 at x=0 is W-1, y+1 at y=H-1 is 0, etc.
REQ-033 LIFE_WRAP_EN undefined: cells outside the grid count as dead (fixed dead border).
REQ-034 Macro SHALL affect only neighbour indexing; timing, handshake, and reset are identical in both builds.

Verification
REQ-035 Blinker: load (3,2),(3,3),(3,4) on 8x8, Start -> Busy 65 cycles, Done pulse, live cells (2,3),(3,3),(4,3), Gen_count=1.
REQ-036 Block still life: load (1,1),(2,1),(1,2),(2,2), 3 back-to-back Starts on Done -> grid unchanged, Gen_count=3.
REQ-037 Corner, LIFE_WRAP_EN defined: load (0,0),(7,0),(0,7) -> after 1 step (7,7) alive plus the 3 seeds; undefined -> all dead.
REQ-038 Reset mid-scan: Start, Rst at cycle 20 of SCAN -> Busy=0 next cycle, no Done, Gen_count=0, all Rd_data=0.
REQ-039 Start and Load_we pulsed during SCAN -> ignored: single Done after 65 cycles, loaded cell unchanged.
REQ-040 Gen_count wrap: GEN_W=2, 4 steps on empty grid -> Gen_count 1,2,3,0.
